// File: rtl/cook_if.sv
// Front-panel bus of the microwave sequencer: buttons, door, keypad in; display digits, magnetron and status out.
interface cook_if;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       done;
    logic [2:0] state;

    modport master (
        output startn, stopn, clearn, door_closed, key_valid, key_digit,
        input  min_tens, min_ones, sec_tens, sec_ones, mag_on, done, state
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, key_valid, key_digit,
        output min_tens, min_ones, sec_tens, sec_ones, mag_on, done, state
    );
endinterface

// File: rtl/cook_controller.sv
// Microwave sequencer: keypad MM:SS entry, BCD countdown, start/stop/clear/door policy.
// Optional macro COOK_ADD30_EN: start while cooking adds 30 s; start in IDLE at 00:00 cooks 00:30.
module cook_controller #(
    parameter int TICKS_PER_SEC = 100,
    parameter int CNT_W         = 7
) (
    input  logic   clk,
    input  logic   rst,
    cook_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        time_q, time_d;   // {min_tens, min_ones, sec_tens, sec_ones}
    logic [CNT_W-1:0]   pre_q, pre_d;
    logic               startn_q, stopn_q, clearn_q;

    logic start_p, stop_p, clear_p;
    logic key_ok, time_zero, tick;
    logic [CNT_W-1:0] pre_inc;

    assign start_p   = startn_q & ~bus.startn;
    assign stop_p    = stopn_q  & ~bus.stopn;
    assign clear_p   = clearn_q & ~bus.clearn;
    assign key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);
    assign time_zero = (time_q == 16'h0000);
    assign tick      = (pre_q == CNT_W'(TICKS_PER_SEC - 1));
    assign pre_inc   = tick ? '0 : pre_q + CNT_W'(1);

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef COOK_ADD30_EN
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [15:0] r;
        logic [3:0]  st;
        r  = t;
        st = t[7:4] + 4'd3;
        if (st >= 4'd6) begin
            st = st - 4'd6;
            if (t[11:8] != 4'd9) begin
                r[11:8] = t[11:8] + 4'd1;
            end else begin
                r[11:8]  = 4'd0;
                r[15:12] = t[15:12] + 4'd1;
            end
        end
        r[7:4] = st;
        // Carry out of 99 minutes pins the display at its maximum.
        if (st >= 4'd0 && t[15:8] == 8'h99 && (t[7:4] + 4'd3) >= 4'd6) begin
            r = 16'h9959;
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = '0;
        if (clear_p) begin
            state_d = IDLE;
            time_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef COOK_ADD30_EN
                    if (start_p && bus.door_closed && time_zero) begin
                        state_d = COOKING;
                        time_d  = 16'h0030;
                    end else
`endif
                    if (key_ok) begin
                        state_d = ENTRY;
                        time_d  = {time_q[11:0], bus.key_digit};
                    end
                end
                ENTRY: begin
                    if (stop_p) begin
                        state_d = IDLE;
                        time_d  = '0;
                    end else if (start_p && bus.door_closed && !time_zero) begin
                        state_d = COOKING;
                    end else if (key_ok) begin
                        time_d = {time_q[11:0], bus.key_digit};
                    end
                end
                COOKING: begin
                    if (stop_p || !bus.door_closed) begin
                        state_d = PAUSED;
`ifdef COOK_ADD30_EN
                    end else if (start_p) begin
                        time_d = bcd_add30(time_q);
                        pre_d  = pre_inc;
`endif
                    end else begin
                        pre_d = pre_inc;
                        if (tick) begin
                            time_d = bcd_dec(time_q);
                            if (time_q == 16'h0001) state_d = DONE;
                        end
                    end
                end
                PAUSED: begin
                    if (stop_p) begin
                        state_d = IDLE;
                        time_d  = '0;
                    end else if (start_p && bus.door_closed && !time_zero) begin
                        state_d = COOKING;
                    end
                end
                DONE: begin
                    if (stop_p || !bus.door_closed) begin
                        state_d = IDLE;
                        time_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            time_q   <= '0;
            pre_q    <= '0;
            startn_q <= 1'b1;
            stopn_q  <= 1'b1;
            clearn_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            pre_q    <= pre_d;
            startn_q <= bus.startn;
            stopn_q  <= bus.stopn;
            clearn_q <= bus.clearn;
        end
    end

    assign bus.min_tens = time_q[15:12];
    assign bus.min_ones = time_q[11:8];
    assign bus.sec_tens = time_q[7:4];
    assign bus.sec_ones = time_q[3:0];
    assign bus.state    = state_q;
    assign bus.mag_on   = (state_q == COOKING) && bus.door_closed;
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_cook_controller.sv
// Self-checking bench for cook_controller: directed scenarios plus random stimulus against a seconds-level model.
module tb_cook_controller;
    localparam int TPS = 4;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSED = 3, S_DONE = 4;
`ifdef COOK_ADD30_EN
    localparam bit ADD30 = 1'b1;
`else
    localparam bit ADD30 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    cook_if bus();

    cook_controller #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: time held as integer minutes and seconds
    int m_state, m_mm, m_ss, m_pre;
    bit m_ps, m_pt, m_pc;
    int n_state, n_mm, n_ss, n_pre;
    bit n_ps, n_pt, n_pc;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_time();
        return int'({bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones});
    endfunction

    function automatic int model_time();
        return ((m_mm / 10) << 12) | ((m_mm % 10) << 8) | ((m_ss / 10) << 4) | (m_ss % 10);
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_mm = 0; m_ss = 0; m_pre = 0;
        m_ps = 1'b1; m_pt = 1'b1; m_pc = 1'b1;
    endtask

    task automatic model_enter(input int d);
        int n;
        n = ((m_mm * 100 + m_ss) * 10 + d) % 10000;
        n_mm = n / 100;
        n_ss = n % 100;
    endtask

    task automatic model_next();
        bit sp, tp, cp, zero, kok, dc;
        sp   = m_ps && !bus.startn;
        tp   = m_pt && !bus.stopn;
        cp   = m_pc && !bus.clearn;
        dc   = bus.door_closed;
        zero = (m_mm == 0) && (m_ss == 0);
        kok  = bus.key_valid && (int'(bus.key_digit) <= 9);
        n_state = m_state; n_mm = m_mm; n_ss = m_ss; n_pre = 0;
        n_ps = bus.startn; n_pt = bus.stopn; n_pc = bus.clearn;
        if (cp) begin
            n_state = S_IDLE; n_mm = 0; n_ss = 0;
        end else if (m_state == S_IDLE) begin
            if (ADD30 && sp && dc && zero) begin
                n_state = S_COOK; n_ss = 30;
            end else if (kok) begin
                model_enter(int'(bus.key_digit)); n_state = S_ENTRY;
            end
        end else if (m_state == S_ENTRY) begin
            if (tp) begin
                n_state = S_IDLE; n_mm = 0; n_ss = 0;
            end else if (sp && dc && !zero) begin
                n_state = S_COOK;
            end else if (kok) begin
                model_enter(int'(bus.key_digit));
            end
        end else if (m_state == S_COOK) begin
            if (tp || !dc) begin
                n_state = S_PAUSED;
            end else begin
                n_pre = (m_pre + 1) % TPS;
                if (ADD30 && sp) begin
                    n_ss = m_ss + 30;
                    if (n_ss >= 60) begin
                        n_ss -= 60;
                        n_mm = m_mm + 1;
                        if (n_mm > 99) begin n_mm = 99; n_ss = 59; end
                    end
                end else if (m_pre == TPS - 1) begin
                    if (m_ss > 0) n_ss = m_ss - 1;
                    else begin n_ss = 59; n_mm = m_mm - 1; end
                    if (n_mm == 0 && n_ss == 0) n_state = S_DONE;
                end
            end
        end else if (m_state == S_PAUSED) begin
            if (tp) begin
                n_state = S_IDLE; n_mm = 0; n_ss = 0;
            end else if (sp && dc && !zero) begin
                n_state = S_COOK;
            end
        end else if (m_state == S_DONE) begin
            if (tp || !dc) begin
                n_state = S_IDLE; n_mm = 0; n_ss = 0;
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_next();
            @(posedge clk);
            m_state = n_state; m_mm = n_mm; m_ss = n_ss; m_pre = n_pre;
            m_ps = n_ps; m_pt = n_pt; m_pc = n_pc;
            @(negedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(bus.state), m_state);
            chk("digits", dut_time(), model_time());
            chk("mag_on", int'(bus.mag_on), int'(m_state == S_COOK && bus.door_closed));
            chk("done", int'(bus.done), int'(m_state == S_DONE));
        end
    end

    task automatic key(input int d);
        bus.key_valid = 1'b1;
        bus.key_digit = 4'(d);
        cyc(1);
        bus.key_valid = 1'b0;
    endtask

    task automatic press(input bit s, input bit t, input bit c);
        bus.startn = !s; bus.stopn = !t; bus.clearn = !c;
        cyc(1);
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk); #1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_digits", dut_time(), 'h0000);
        chk("reset_mag", int'(bus.mag_on), 0);
        chk("reset_done", int'(bus.done), 0);
        rst = 1'b0;

        // Entry 01:05, countdown and borrow
        key(1); key(0); key(5);
        chk("entry_105", dut_time(), 'h0105);
        press(1, 0, 0);
        chk("cook_state", int'(bus.state), 2);
        chk("cook_mag", int'(bus.mag_on), 1);
        cyc(4);  chk("t_0104", dut_time(), 'h0104);
        cyc(8);  chk("t_0102", dut_time(), 'h0102);
        cyc(8);  chk("t_0100", dut_time(), 'h0100);
        cyc(4);  chk("t_0059", dut_time(), 'h0059);

        // Run to DONE, then door open returns to IDLE
        press(0, 0, 1);
        chk("clear_idle", int'(bus.state), 0);
        key(0); key(2);
        press(1, 0, 0);
        chk("short_mag", int'(bus.mag_on), 1);
        cyc(8);
        chk("done_state", int'(bus.state), 4);
        chk("done_flag", int'(bus.done), 1);
        chk("done_mag", int'(bus.mag_on), 0);
        chk("done_digits", dut_time(), 'h0000);
        bus.door_closed = 1'b0;
        cyc(1);
        chk("done_exit", int'(bus.state), 0);
        chk("done_clr", int'(bus.done), 0);
        bus.door_closed = 1'b1;

        // Door opens mid-cook
        key(1); key(0);
        press(1, 0, 0);
        cyc(2);
        bus.door_closed = 1'b0;
        #1;
        chk("door_mag_now", int'(bus.mag_on), 0);
        cyc(1);
        chk("door_paused", int'(bus.state), 3);
        cyc(5);
        bus.door_closed = 1'b1;
        cyc(3);
        chk("still_paused", int'(bus.state), 3);
        chk("frozen_time", dut_time(), 'h0010);
        press(1, 0, 0);
        chk("resume", int'(bus.state), 2);
        cyc(4);
        chk("resume_tick", dut_time(), 'h0009);

        // Start refused: door open, or zero time
        press(0, 0, 1);
        key(2); key(0);
        bus.door_closed = 1'b0;
        press(1, 0, 0);
        chk("start_door_open", int'(bus.state), 1);
        bus.door_closed = 1'b1;
        press(0, 0, 1);
        key(0);
        press(1, 0, 0);
        chk("start_zero", int'(bus.state), 1);
        chk("start_zero_mag", int'(bus.mag_on), 0);
        key(5);
        press(1, 0, 0);
        press(1, 1, 1);
        chk("multi_state", int'(bus.state), 0);
        chk("multi_digits", dut_time(), 'h0000);

        // Invalid digit, then async reset mid-cook
        key(3);
        key(12);
        chk("bad_digit", dut_time(), 'h0003);
        press(1, 0, 0);
        cyc(1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mag_async", int'(bus.mag_on), 0);
        chk("rst_state_async", int'(bus.state), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        cyc(1);
        chk("post_rst_digits", dut_time(), 'h0000);

`ifdef COOK_ADD30_EN
        key(4); key(5);
        press(1, 0, 0);
        cyc(1);
        press(1, 0, 0);
        chk("add_0115", dut_time(), 'h0115);
        press(0, 0, 1);
        key(9); key(9); key(4); key(5);
        press(1, 0, 0);
        cyc(1);
        press(1, 0, 0);
        chk("add_sat", dut_time(), 'h9959);
        press(0, 0, 1);
        press(1, 0, 0);
        chk("idle_add_state", int'(bus.state), 2);
        chk("idle_add_time", dut_time(), 'h0030);
        press(0, 0, 1);
`endif

        for (int i = 0; i < 4000; i++) begin
            bus.startn    = ($urandom_range(0, 4) != 0);
            bus.stopn     = ($urandom_range(0, 24) != 0);
            bus.clearn    = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 29) == 0) bus.door_closed = !bus.door_closed;
            bus.key_valid = ($urandom_range(0, 3) == 0);
            bus.key_digit = 4'($urandom_range(0, 15));
            cyc(1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cook_controller.md
Name: cook_controller

Overview:
- Top-level microwave sequencer: FSM, keypad time entry, and an internal 4-digit BCD MM:SS countdown.
- Drives `mag_on`, which replaces the standalone SR-latch magnetron enable.
- Owns the start/stop/clear/door policy; feeds the display digits and the done indicator.

Parameters:
- TICKS_PER_SEC, 100: clk cycles per countdown second. Minimum 2.
- CNT_W, 7: width of the prescaler counter. Must satisfy 2^CNT_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- startn  input  1  start button, active-low, synchronous to clk
- stopn  input  1  stop/pause button, active-low
- clearn  input  1  clear button, active-low
- door_closed  input  1  1 = door closed
- key_valid  input  1  single-cycle strobe, key_digit valid
- key_digit  input  4  keypad digit, BCD 0-9
- min_tens  output  4  BCD display digit
- min_ones  output  4  BCD display digit
- sec_tens  output  4  BCD display digit
- sec_ones  output  4  BCD display digit
- mag_on  output  1  magnetron enable
- done  output  1  cook finished indicator
- state  output  3  FSM state code, for debug

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, all digits 0, mag_on=0, done=0, prescaler=0.
  - Button history registers = 1 (released).
- Press detection: press = registered previous value 1 and current value 0 (one-cycle pulse). Holding a button yields exactly one press.
- State encodings: IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4. Codes 5-7 return to IDLE on the next clk.
- Event priority within one cycle: clear > stop > door open > start > key > tick.
- Clear press (any state): next cycle IDLE, digits=00:00, done=0.
- Key entry (IDLE or ENTRY only):
  - On key_valid with key_digit<=9: shift left, i.e. min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - IDLE moves to ENTRY.
  - key_digit>9 is ignored. key_valid in COOKING/PAUSED/DONE is ignored.
- Start press in ENTRY or PAUSED, with door_closed=1 and time!=00:00: goes to COOKING and clears the prescaler. Otherwise start is ignored.
- COOKING:
  - Prescaler counts 0..TICKS_PER_SEC-1. The tick is the cycle at TICKS_PER_SEC-1, after which it wraps to 0. First tick occurs TICKS_PER_SEC cycles after entry.
  - On each tick the time is decremented by 1 s in BCD:
    - sec_ones 0 wraps to 9 and borrows from sec_tens.
    - sec_tens 0 wraps to 5 and borrows from min_ones.
    - min_ones 0 wraps to 9 and borrows from min_tens.
  - Entered seconds above 59 (e.g. 0:90) count down literally.
  - A tick when the time is 00:01 makes the time 00:00; next state DONE, done=1.
- Stop press in COOKING goes to PAUSED with the time held. Stop press in PAUSED or ENTRY goes to IDLE with the time cleared.
- door_closed=0 in COOKING goes to PAUSED next cycle. The prescaler is frozen and reset to 0 on resume.
- mag_on = (state==COOKING) AND door_closed, combinational. An opening door therefore drops mag_on in the same cycle.
- DONE:
  - mag_on=0, done=1, time 00:00.
  - Leaves to IDLE (done=0) on a clear or stop press, or when door_closed=0.
  - Start press is ignored.
- Prescaler is held at 0 in every state except COOKING.
- Mid-operation reset forces mag_on=0 immediately (asynchronously).

Optional Feature:
- Macro: COOK_ADD30_EN.
- Defined:
  - Start press in COOKING adds 30 s: sec_tens+3; if the result is >=6, subtract 6 and increment the BCD minutes.
  - Minute overflow past 99 saturates the time at 99:59.
  - Start press in IDLE with time 00:00 and door closed loads 00:30 and enters COOKING.
  - The prescaler is not cleared by an add.
- Undefined: start in COOKING and start in IDLE are ignored. No add logic is synthesized.

Test Plan (TICKS_PER_SEC=4):
- Keys 1,0,5, close door, start press -> digits 01:05, mag_on=1. After 4 cycles 01:04; after 8 more cycles 01:02. Borrow case: from 01:00 one tick gives 00:59.
- Load 00:02, start -> mag_on=1; after 8 cycles state=DONE, done=1, mag_on=0, 00:00. Door open -> IDLE, done=0.
- Cooking 00:10, door_closed 1->0 -> mag_on=0 in the same cycle, state=PAUSED, time frozen. Door close with no start -> stays PAUSED. Start -> COOKING resumes from the frozen time.
- Start with door open at 00:20, and start with time 00:00 -> state unchanged, mag_on stays 0. Stop, clear and start pressed in the same cycle while COOKING -> IDLE, 00:00.
- key_digit=12 strobed -> digits unchanged. rst asserted mid-COOKING -> mag_on=0 asynchronously; after release, IDLE and 00:00.
- COOK_ADD30_EN only:
  - Cooking 00:45, start -> 01:15.
  - Cooking 99:45, start -> 99:59.
  - IDLE at 00:00, door closed, start -> COOKING at 00:30.
